cla_iterative_addsub: RTL

//  Multi-cycle WIDTH-bit adder/subtractor for the 8-bit RISC datapath.

---
 rtl/alu_pkg.sv | 8 +
 rtl/cla2_slice.sv | 20 ++
 rtl/cla_iterative_addsub.sv | 131 +++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared types and constants for the iterative carry-lookahead adder/subtractor.
package alu_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} addsub_state_t;

  localparam int SLICE_W = 2;

endpackage

// File: rtl/cla2_slice.sv
// Combinational 2-bit carry-lookahead add: generate/propagate per bit, both carries in parallel.
module cla2_slice (
  input  logic [1:0] a,
  input  logic [1:0] b,
  input  logic       cin,
  output logic [1:0] s,
  output logic       cout
);

  logic [1:0] g;
  logic [1:0] p;
  logic       c1;

  assign g    = a & b;
  assign p    = a ^ b;
  assign c1   = g[0] | (p[0] & cin);
  assign cout = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign s    = p ^ {c1, cin};

endmodule

// File: rtl/cla_iterative_addsub.sv
// Multi-cycle adder/subtractor: one 2-bit CLA slice per cycle with a registered carry.
// Optional EARLY_TERM_EN: finish as soon as no carry remains and the upper operand bits are zero.
module cla_iterative_addsub
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             op_sub,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero,
  output addsub_state_t    state
);

  localparam int N  = WIDTH / SLICE_W;
  localparam int CW = $clog2(N);

  generate
    if ((WIDTH % 2) != 0 || WIDTH < 4) begin : g_bad_width
      $error("cla_iterative_addsub: WIDTH must be even and >= 4");
    end
  endgenerate

  // Handshake: a transfer happens on a rising edge where valid & ready are both high;
  // res_valid and the result/flags stay stable until res_ready is seen.

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             carry_q;
  logic [CW-1:0]    count_q;

  logic [SLICE_W-1:0] slice_a;
  logic [SLICE_W-1:0] slice_b;
  logic [SLICE_W-1:0] slice_s;
  logic               slice_cout;
  logic [WIDTH-1:0]   res_n;
  logic               stop;
  int                 lo;

  assign start_ready = (state == IDLE);

  cla2_slice u_slice (
    .a    (slice_a),
    .b    (slice_b),
    .cin  (carry_q),
    .s    (slice_s),
    .cout (slice_cout)
  );

`ifdef EARLY_TERM_EN
  logic [WIDTH-1:0] a_rest;
  logic [WIDTH-1:0] b_rest;
`endif

  always_comb begin
    lo      = SLICE_W * int'(count_q);
    slice_a = a_q[lo +: SLICE_W];
    slice_b = b_q[lo +: SLICE_W];
    res_n   = result;
    res_n[lo +: SLICE_W] = slice_s;
    stop    = (count_q == CW'(N - 1));
`ifdef EARLY_TERM_EN
    a_rest = a_q >> (lo + SLICE_W);
    b_rest = b_q >> (lo + SLICE_W);
    if (!slice_cout && a_rest == '0 && b_rest == '0) begin
      stop  = 1'b1;
      res_n = res_n & ~({WIDTH{1'b1}} << (lo + SLICE_W));
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      carry_q   <= 1'b0;
      count_q   <= '0;
      result    <= '0;
      res_valid <= 1'b0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
      zero      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_valid) begin
            a_q       <= op_a;
            b_q       <= op_sub ? ~op_b : op_b;
            carry_q   <= op_sub;
            count_q   <= '0;
            result    <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
            zero      <= 1'b0;
            state     <= RUN;
          end
        end
        RUN: begin
          result  <= res_n;
          carry_q <= slice_cout;
          count_q <= count_q + CW'(1);
          if (stop) begin
            state     <= DONE;
            res_valid <= 1'b1;
            carry_out <= slice_cout;
            zero      <= (res_n == '0);
            overflow  <= (a_q[WIDTH-1] == b_q[WIDTH-1]) && (res_n[WIDTH-1] != a_q[WIDTH-1]);
          end
        end
        DONE: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
